// File: rtl/aes_round_ctrl_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
// Holds the FSM state enum and the per-round datapath bypass decode.
package aes_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int AES128_ROUNDS = 10;
    localparam int AES_RND_W     = 4;

    // Returns {en_sub, en_shift, en_mix, sel_plaintext} for a round.
    // Round 0 is the bare initial AddKey; the final round skips MixColumns.
    function automatic logic [3:0] bypass_vec(input int unsigned rnd,
                                              input int unsigned num_rounds);
        if (rnd == 0) begin
            return 4'b0001;
        end else if (rnd >= num_rounds) begin
            return 4'b1100;
        end else begin
            return 4'b1110;
        end
    endfunction

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Control bundle between the round sequencer (slave) and the requester/datapath (master).
// Handshakes: a transfer happens on a rising edge where valid & ready are both 1;
// out_valid is held until out_ready, start is taken only when start_ready is high.
interface aes_round_ctrl_if
    import aes_ctrl_pkg::*;
#(
    parameter int RND_W = AES_RND_W
) ();

    logic             key_ready;
    logic             start_valid;
    logic             start_ready;
    logic             abort;
    logic             sel_plaintext;
    logic             en_sub;
    logic             en_shift;
    logic             en_mix;
    logic             stage_en;
    logic [RND_W-1:0] rk_sel;
    logic [RND_W-1:0] round;
    logic             busy;
    logic             out_valid;
    logic             out_ready;
    state_t           state;

    modport master (
        output key_ready, start_valid, abort, out_ready,
        input  start_ready, sel_plaintext, en_sub, en_shift, en_mix, stage_en,
               rk_sel, round, busy, out_valid, state
    );

    modport slave (
        input  key_ready, start_valid, abort, out_ready,
        output start_ready, sel_plaintext, en_sub, en_shift, en_mix, stage_en,
               rk_sel, round, busy, out_valid, state
    );

endinterface

// File: rtl/aes_round_ctrl_stage_timer.sv
// Round window counter: counts 0..STAGE_LAT-1 while run is high, held at 0 by clr.
// first marks the strobe cycle of a window, last marks the cycle before the next window.
module aes_stage_timer #(
    parameter int STAGE_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic first,
    output logic last
);

    localparam int CW = 4;

    logic [CW-1:0] cnt;

    assign first = (cnt == '0);
    assign last  = (cnt == CW'(STAGE_LAT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= '0;
        end else if (run) begin
            cnt <= last ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 encrypt round sequencer: walks initial AddKey plus rounds 1..NUM_ROUNDS,
// driving key select, stage bypasses and capture strobes; control only, no data.
module aes_round_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int NUM_ROUNDS = AES128_ROUNDS,
    parameter int STAGE_LAT  = 1,
    parameter int RND_W      = AES_RND_W
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    aes_round_ctrl_if.slave bus
);

    if (NUM_ROUNDS >= (1 << RND_W)) begin : g_bad_rounds
        $error("NUM_ROUNDS does not fit in RND_W bits");
    end
    if (STAGE_LAT < 1 || STAGE_LAT > 15) begin : g_bad_lat
        $error("STAGE_LAT must be within 1..15");
    end

    localparam logic [RND_W-1:0] LAST_RND = RND_W'(NUM_ROUNDS);

    state_t           state;
    logic [RND_W-1:0] round_q;
    logic [3:0]       byp_q;
    logic             busy_q;
    logic             out_valid_q;
    logic             win_first;
    logic             win_last;
    logic             accept;

    assign accept = (state == IDLE) && bus.key_ready && bus.start_valid;

    aes_stage_timer #(
        .STAGE_LAT (STAGE_LAT)
    ) u_timer (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   ((state != ROUND) || bus.abort),
        .run   (state == ROUND),
        .first (win_first),
        .last  (win_last)
    );

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            round_q     <= '0;
            byp_q       <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // abort is deliberately ignored here so it never blocks a start
                    if (accept) begin
                        state   <= ROUND;
                        round_q <= '0;
                        busy_q  <= 1'b1;
                        byp_q   <= bypass_vec(0, NUM_ROUNDS);
                    end
                end
                ROUND: begin
                    if (bus.abort) begin
                        state   <= IDLE;
                        round_q <= '0;
                        byp_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (win_last) begin
                        if (round_q == LAST_RND) begin
                            state       <= DONE;
                            byp_q       <= '0;
                            busy_q      <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            round_q <= round_q + 1'b1;
                            byp_q   <= bypass_vec(32'(round_q) + 32'd1, NUM_ROUNDS);
                        end
                    end
                end
                DONE: begin
                    if (bus.abort || bus.out_ready) begin
                        state       <= IDLE;
                        round_q     <= '0;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.start_ready = (state == IDLE) && bus.key_ready;
    assign bus.stage_en    = busy_q && win_first;
    assign bus.rk_sel      = round_q;
    assign bus.round       = round_q;
    assign bus.busy        = busy_q;
    assign bus.out_valid   = out_valid_q;
    assign {bus.en_sub, bus.en_shift, bus.en_mix, bus.sel_plaintext} = byp_q;
    assign bus.state       = state;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: one instance with STAGE_LAT=1, one with STAGE_LAT=3.
// Expected strobe/round-key order for the first instance is tracked in exp_q.
module tb_aes_round_ctrl;
    import aes_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    aes_round_ctrl_if s1 ();
    aes_round_ctrl_if s3 ();

    aes_round_ctrl #(.NUM_ROUNDS(10), .STAGE_LAT(1), .RND_W(4)) dut1 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (s1.slave)
    );

    aes_round_ctrl #(.NUM_ROUNDS(10), .STAGE_LAT(3), .RND_W(4)) dut3 (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (s3.slave)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_keys(input int last_rk);
        for (int k = 0; k <= last_rk; k++) exp_q.push_back(4'(k));
    endtask

    // Each observed strobe must match the next expected round-key index.
    always @(negedge clk) begin
        if (s1.stage_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_extra: unexpected strobe rk_sel=%0d at %0t", s1.rk_sel, $time);
            end else begin
                check("sb_rk_sel", 32'(s1.rk_sel), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic check_idle1(input string tag);
        check({tag, "_state"},     32'(s1.state), 32'(IDLE));
        check({tag, "_round"},     32'(s1.round), 0);
        check({tag, "_rk_sel"},    32'(s1.rk_sel), 0);
        check({tag, "_busy"},      32'(s1.busy), 0);
        check({tag, "_out_valid"}, 32'(s1.out_valid), 0);
        check({tag, "_stage_en"},  32'(s1.stage_en), 0);
        check({tag, "_en_vec"},    32'({s1.en_sub, s1.en_shift, s1.en_mix, s1.sel_plaintext}), 0);
    endtask

    task automatic check_round1(input int r);
        check("r_stage_en", 32'(s1.stage_en), 1);
        check("r_rk_sel",   32'(s1.rk_sel), 32'(r));
        check("r_busy",     32'(s1.busy), 1);
        check("r_sel_pt",   32'(s1.sel_plaintext), 32'(r == 0));
        check("r_en_sub",   32'(s1.en_sub), 32'(r != 0));
        check("r_en_shift", 32'(s1.en_shift), 32'(r != 0));
        check("r_en_mix",   32'(s1.en_mix), 32'(r != 0 && r != 10));
        check("r_out_valid", 32'(s1.out_valid), 0);
    endtask

    task automatic start1();
        s1.start_valid = 1'b1;
        tick();
        s1.start_valid = 1'b0;
    endtask

    task automatic handshake1();
        s1.out_ready = 1'b1;
        tick();
        s1.out_ready = 1'b0;
    endtask

    initial begin
        s1.key_ready = 1'b1; s1.start_valid = 1'b0; s1.abort = 1'b0; s1.out_ready = 1'b0;
        s3.key_ready = 1'b1; s3.start_valid = 1'b0; s3.abort = 1'b0; s3.out_ready = 1'b0;

        // Reset state
        tick(); tick();
        check_idle1("rst");
        check("rst_start_ready", 32'(s1.start_ready), 1);
        rst_n = 1'b1;
        tick();

        // Single operation, STAGE_LAT=1: strobes in cycles 1..11, out_valid in 12
        push_keys(10);
        check("op_start_ready", 32'(s1.start_ready), 1);
        start1();
        for (int r = 0; r <= 10; r++) begin
            check_round1(r);
            tick();
        end
        check("op_out_valid", 32'(s1.out_valid), 1);
        check("op_busy",      32'(s1.busy), 0);
        check("op_stage_en",  32'(s1.stage_en), 0);
        check("op_round",     32'(s1.round), 10);
        check("op_state",     32'(s1.state), 32'(DONE));

        // Backpressure: out_valid held, no start possible
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid",   32'(s1.out_valid), 1);
            check("bp_start_ready", 32'(s1.start_ready), 0);
            tick();
        end
        handshake1();
        check("bp_out_valid_drop", 32'(s1.out_valid), 0);
        check("bp_start_ready_up", 32'(s1.start_ready), 1);
        check("bp_state",          32'(s1.state), 32'(IDLE));

        // key_ready low blocks start
        s1.key_ready = 1'b0;
        s1.start_valid = 1'b1;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("kr_start_ready", 32'(s1.start_ready), 0);
            check("kr_stage_en",    32'(s1.stage_en), 0);
            check("kr_busy",        32'(s1.busy), 0);
            tick();
        end
        s1.key_ready = 1'b1;
        #1;
        check("kr_accept_ready", 32'(s1.start_ready), 1);
        push_keys(5);
        tick();
        s1.start_valid = 1'b0;

        // Abort in round 5
        for (int r = 0; r <= 4; r++) begin
            check_round1(r);
            tick();
        end
        check_round1(5);
        s1.abort = 1'b1;
        tick();
        s1.abort = 1'b0;
        check_idle1("abort");
        tick();

        // Start together with abort in IDLE is accepted, then a full run
        push_keys(10);
        s1.abort = 1'b1;
        start1();
        s1.abort = 1'b0;
        for (int r = 0; r <= 10; r++) begin
            check_round1(r);
            tick();
        end
        check("ab_out_valid", 32'(s1.out_valid), 1);
        handshake1();
        check("ab_idle", 32'(s1.state), 32'(IDLE));

        // Reset during round 7
        push_keys(7);
        start1();
        for (int r = 0; r <= 6; r++) tick();
        check("r7_round", 32'(s1.round), 7);
        check("r7_stage_en", 32'(s1.stage_en), 1);
        rst_n = 1'b0;
        tick();
        check_idle1("rst_r7");
        tick();
        check("rst_r7_hold_stage_en", 32'(s1.stage_en), 0);
        rst_n = 1'b1;
        tick();

        // Reset during DONE
        push_keys(10);
        start1();
        for (int r = 0; r <= 10; r++) tick();
        check("dn_out_valid", 32'(s1.out_valid), 1);
        rst_n = 1'b0;
        tick();
        check_idle1("rst_done");
        rst_n = 1'b1;
        tick();

        // STAGE_LAT=3: strobes at 1,4,..,31, out_valid at cycle 34
        s3.start_valid = 1'b1;
        tick();
        s3.start_valid = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            int w;
            w = (c - 1) / 3;
            check("l3_stage_en",  32'(s3.stage_en), 32'((c - 1) % 3 == 0));
            check("l3_rk_sel",    32'(s3.rk_sel), 32'(w));
            check("l3_sel_pt",    32'(s3.sel_plaintext), 32'(w == 0));
            check("l3_en_sub",    32'(s3.en_sub), 32'(w != 0));
            check("l3_en_mix",    32'(s3.en_mix), 32'(w != 0 && w != 10));
            check("l3_out_valid", 32'(s3.out_valid), 0);
            tick();
        end
        check("l3_done_valid", 32'(s3.out_valid), 1);
        check("l3_done_busy",  32'(s3.busy), 0);
        s3.out_ready = 1'b1;
        tick();
        s3.out_ready = 1'b0;
        check("l3_idle_valid", 32'(s3.out_valid), 0);
        check("l3_idle_ready", 32'(s3.start_ready), 1);

        tick();
        check("sb_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
